aes_round_sequencer: RTL
========================

// Module: aes_round_sequencer
// PURPOSE
//  Iterative AES-128 encryption controller. Accepts one plaintext/key pair over a valid/ready
//  handshake and runs the initial AddRoundKey plus NR rounds, one round per clock.
//  Round datapath per cycle: SubBytes -> ShiftRows -> MixColumns (skipped in the final round) -> AddRoundKey.
//  Round keys are expanded on the fly. Ciphertext leaves on a valid/ready handshake.
//  Sits between the top-level host interface and the existing combinational round primitives.
// PARAMETERS
//  NR     10  number of rounds; only 10 (AES-128) is legal, elaborate-time error otherwise
//  CNT_W  4   round counter width; must satisfy 2**CNT_W > NR
// PORTS
//  clk        in   1    single clock, all state updates on rising edge
//  reset      in   1    synchronous, active-high reset
//  in_valid   in   1    plaintext/key presented
//  in_ready   out  1    controller can accept; high only in IDLE
//  plaintext  in   128  byte 0 = [127:120], column-major per FIPS-197
//  key        in   128  cipher key, same byte order
//  out_valid  out  1    ciphertext valid; held until accepted
//  out_ready  in   1    downstream accepts ciphertext
//  ciphertext out  128  result, same byte order; stable while out_valid=1
//  busy       out  1    high in ROUND or DONE
// BEHAVIOUR
//  - Reset (synchronous, active-high): FSM=IDLE; round_cnt=0; state_reg=0; key_reg=0.
//    Outputs: in_ready=1, out_valid=0, busy=0, ciphertext=0. Reset mid-operation discards the
//    block in flight; nothing is emitted.
//  - FSM states: IDLE, ROUND, DONE.
//  - IDLE:
//    * in_valid & in_ready on edge E0: state_reg <= plaintext ^ key; key_reg <= key;
//      round_cnt <= 1; -> ROUND.
//    * in_valid=0: stay in IDLE.
//  - ROUND, each edge:
//    * key_next = expand(key_reg, rcon(round_cnt)).
//    * state_reg <= round(state_reg, key_next, last = (round_cnt==NR)).
//    * key_reg <= key_next; round_cnt <= round_cnt+1.
//    * When round_cnt==NR: -> DONE, round_cnt <= 0.
//  - DONE: out_valid=1; ciphertext=state_reg.
//    * out_ready=1: -> IDLE on that edge.
//    * out_ready=0: hold, with ciphertext stable.
//  - Latency: out_valid rises NR edges after the accept edge E0 (E0+10).
//    Throughput: one block per NR+2 cycles at minimum.
//  - No bypass: in_ready is 0 in the DONE cycle even when out_ready=1. A new block is
//    accepted at the earliest one cycle after the handshake.
//  - in_valid in ROUND/DONE is ignored (in_ready=0). plaintext/key are sampled only on E0
//    and may change afterwards.
//  - out_ready in IDLE/ROUND has no effect.
//  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10. It is a GF(2^8) xtime
//    chain; the 8-bit wrap through 0x1b after 0x80 is mandatory.
//  - MixColumns arithmetic: GF(2^8) modulo x^8+x^4+x^3+x+1. All XOR; no carries.
//  - round_cnt never exceeds NR; any illegal FSM encoding recovers to IDLE.
// STRUCTURE
//  - Shared package aes_pkg:
//    * FSM state typedef/encodings.
//    * function rcon(round) -> 8-bit.
//    * S-box table / function.
//    * xtime and gf_mul2/gf_mul3 functions.
//    * AES_NR=10 constant.
//    * byte-index helper for column-major mapping.
//  - One sub-module: aes_key_round.
//    * Combinational; inputs key_in[127:0], rcon[7:0]; output key_out[127:0].
//    * RotWord + SubWord + rcon on the last word, then the XOR chain.
//  - Round datapath reuses the team's SubBytes, ShiftRows and MixColumns primitives
//    combinationally. A mux selects the MixColumns bypass on the last round.
//  - One 128-bit state register, one 128-bit key register, CNT_W counter, 2-bit FSM register.
// TESTING
//  1. FIPS-197 App.B: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734
//     -> ct=3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after accept.
//  2. FIPS-197 App.C.1: key=000102030405060708090a0b0c0d0e0f,
//     pt=00112233445566778899aabbccddeeff -> ct=69c4e0d86a7b0430d8cdb78070b4c55a.
//  3. Backpressure: vector 1 with out_ready=0 for 5 cycles after out_valid.
//     -> ct stable, in_ready=0 throughout; returns to IDLE the edge after out_ready=1.
//  4. Back-to-back: in_valid held high with vectors 1 then 2, out_ready=1.
//     -> both cts correct, in order; second accept occurs 12 cycles after the first.
//  5. Reset mid-operation: assert reset at round 5 of vector 1.
//     -> next cycle in_ready=1, out_valid=0, busy=0; no ct emitted. Then vector 2 -> correct ct.
//  6. Input change after accept: alter plaintext/key on cycle E0+1.
//     -> ct still equals the vector-1 result; in_valid during ROUND ignored.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, GF(2^8) arithmetic, S-box and
// the SubBytes / ShiftRows / MixColumns round primitives on column-major blocks.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    function automatic int byte_idx(input int col, input int row);
        return col * 4 + row;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] blk, input int idx);
        return blk[127 - 8 * idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? aa : 8'h00);
            aa  = xtime(aa);
        end
        return acc;
    endfunction

    // Round constants 1..10; the xtime chain wraps 0x80 -> 0x1b.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 2; i <= 10; i++) begin
            r = (i <= int'(round)) ? xtime(r) : r;
        end
        return r;
    endfunction

    // S-box as multiplicative inverse (b^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] inv;
        p   = b;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] blk);
        logic [127:0] o;
        o = 128'd0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = sbox(get_byte(blk, i));
        end
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] blk);
        logic [127:0] o;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * byte_idx(c, r) -: 8] = get_byte(blk, byte_idx((c + r) % 4, r));
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] blk);
        logic [127:0] o;
        logic [7:0]   s0, s1, s2, s3;
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            s0 = get_byte(blk, byte_idx(c, 0));
            s1 = get_byte(blk, byte_idx(c, 1));
            s2 = get_byte(blk, byte_idx(c, 2));
            s3 = get_byte(blk, byte_idx(c, 3));
            o[127 - 8 * byte_idx(c, 0) -: 8] = gf_mul2(s0) ^ gf_mul3(s1) ^ s2 ^ s3;
            o[127 - 8 * byte_idx(c, 1) -: 8] = s0 ^ gf_mul2(s1) ^ gf_mul3(s2) ^ s3;
            o[127 - 8 * byte_idx(c, 2) -: 8] = s0 ^ s1 ^ gf_mul2(s2) ^ gf_mul3(s3);
            o[127 - 8 * byte_idx(c, 3) -: 8] = gf_mul3(s0) ^ s1 ^ s2 ^ gf_mul2(s3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// One step of the AES-128 key schedule: derives the next round key from the
// current one and the round constant.
module aes_key_round
    import aes_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] key_out
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0 = key_in[127:96];
    assign w_w1 = key_in[95:64];
    assign w_w2 = key_in[63:32];
    assign w_w3 = key_in[31:0];

    // RotWord + SubWord + rcon applied to the last word only.
    assign w_rot  = {w_w3[23:0], w_w3[31:24]};
    assign w_temp = {sbox(w_rot[31:24]) ^ rcon, sbox(w_rot[23:16]),
                     sbox(w_rot[15:8]), sbox(w_rot[7:0])};

    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign key_out = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: one round per clock, on-the-fly key
// expansion, valid/ready handshakes on both the plaintext and ciphertext sides.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    if (NR != AES_NR) begin : g_bad_nr
        $error("aes_round_sequencer: only NR=10 is supported");
    end
    if ((2 ** CNT_W) <= NR) begin : g_bad_cnt_w
        $error("aes_round_sequencer: CNT_W too narrow for NR");
    end

    aes_state_e         r_fsm;
    aes_state_e         w_fsm_next;
    logic [CNT_W-1:0]   r_round_cnt;
    logic [127:0]       r_state;
    logic [127:0]       r_key;

    logic               w_last;
    logic [7:0]         w_rcon;
    logic [127:0]       w_key_next;
    logic [127:0]       w_shifted;
    logic [127:0]       w_mixed;
    logic [127:0]       w_round_out;

    assign w_last = (r_round_cnt >= CNT_W'(NR));
    assign w_rcon = rcon(r_round_cnt[3:0]);

    aes_key_round u_key_round (
        .key_in  (r_key),
        .rcon    (w_rcon),
        .key_out (w_key_next)
    );

    // Round datapath; the final round bypasses MixColumns.
    assign w_shifted   = shift_rows(sub_bytes(r_state));
    assign w_mixed     = mix_columns(w_shifted);
    assign w_round_out = (w_last ? w_shifted : w_mixed) ^ w_key_next;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        w_fsm_next = ST_IDLE;
        case (r_fsm)
            ST_IDLE:  if (in_valid)  w_fsm_next = ST_ROUND; else w_fsm_next = ST_IDLE;
            ST_ROUND: if (w_last)    w_fsm_next = ST_DONE;  else w_fsm_next = ST_ROUND;
            ST_DONE:  if (out_ready) w_fsm_next = ST_IDLE;  else w_fsm_next = ST_DONE;
            default:  w_fsm_next = ST_IDLE;
        endcase
    end

    // State, key and round counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= 128'd0;
            r_key       <= 128'd0;
            r_round_cnt <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state     <= plaintext ^ key;
                        r_key       <= key;
                        r_round_cnt <= CNT_W'(1);
                    end else begin
                        r_round_cnt <= '0;
                    end
                end
                ST_ROUND: begin
                    r_state     <= w_round_out;
                    r_key       <= w_key_next;
                    r_round_cnt <= w_last ? '0 : r_round_cnt + CNT_W'(1);
                end
                default: begin
                    r_round_cnt <= '0;
                end
            endcase
        end
    end

    // Handshake and status outputs decoded from the FSM register
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        ciphertext = 128'd0;
        case (r_fsm)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_ROUND: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                out_valid  = 1'b1;
                busy       = 1'b1;
                ciphertext = r_state;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule
